// File: rtl/regfile_mp.sv
// Two-read/one-write register file with one input-mapped register fed by a
// synchronized external input, plus sticky rising-edge flags (write-1-to-clear).

module regfile_mp_ioLane (
  input  logic clk,
  input  logic reset,
  input  logic ioIn,
  input  logic clr,
  output logic ioBit,
  output logic press
);
  logic sync1, sync2;

  // Set beats clear on the same edge; rise is judged against the registered copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      ioBit <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= ioIn;
      sync2 <= sync1;
      ioBit <= sync2;
      press <= (sync2 & ~ioBit) | (press & ~clr);
    end
  end
endmodule

module regfile_mp #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int IO_REG  = DEPTH - 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_press
);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IO_A    = AW'(IO_REG);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ioReg;
  logic [WIDTH-1:0] ioClr;
  logic             waddrOk;
  logic             wrHit;

  assign waddrOk = {1'b0, waddr} < DEPTH_W;
  assign wrHit   = we && waddrOk && (waddr != IO_A) &&
                   !((ZERO_R0 != 0) && (waddr == '0));
  assign ioClr   = (we && waddr == IO_A) ? wdata : '0;

  genvar l;
  generate
    for (l = 0; l < WIDTH; l++) begin : gLane
      regfile_mp_ioLane uLane (
        .clk   (clk),
        .reset (reset),
        .ioIn  (io_in[l]),
        .clr   (ioClr[l]),
        .ioBit (ioReg[l]),
        .press (io_press[l])
      );
    end
  endgenerate

  // The IO slot and a forced-zero r0 stay 0 in the array; reads redirect them.
  genvar r;
  generate
    for (r = 0; r < DEPTH; r++) begin : gReg
      localparam bit FIXED = (r == IO_REG) || ((ZERO_R0 != 0) && (r == 0));
      always_ff @(posedge clk) begin
        if (reset || FIXED)
          mem[r] <= '0;
        else if (we && waddr == AW'(r))
          mem[r] <= wdata;
      end
    end
  endgenerate

  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
    if ((BYPASS != 0) && wrHit && (a == waddr)) return wdata;
    if ({1'b0, a} >= DEPTH_W) return '0;
    if (a == IO_A) return ioReg;
    return mem[a];
  endfunction

  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance plus no-bypass and zero-r0/short-depth
// variants sharing the same stimulus; vector table plus IO/reset sequences.

module tb_regfile_mp;
  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, we;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata, io_in;
  logic [W-1:0]  rdA, rdB, press, nbA, nbB, nbPress, zA, zB, zPress;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdA), .rdata_b(rdB),
    .io_in(io_in), .io_press(press));

  regfile_mp #(.BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nbA), .rdata_b(nbB),
    .io_in(io_in), .io_press(nbPress));

  regfile_mp #(.DEPTH(12), .ZERO_R0(1)) dutZ (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(zA), .rdata_b(zB),
    .io_in(io_in), .io_press(zPress));

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra, rb;
    logic [W-1:0]  expA, expB, expNb, expZ;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] expA, expB, expNb, expZ;
  } exp_t;

  vec_t tbl[12];
  exp_t sb[$];
  int   nVec = 0;
  int   nBad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
  endtask

  initial begin
    exp_t e;
    //           we  wa     wd        ra     rb     expA      expB      expNb     expZ
    tbl[0]  = '{1'b1, 4'd3,  16'hBEEF, 4'd3,  4'd4,  16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF};
    tbl[1]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd4,  16'hBEEF, 16'h0000, 16'hBEEF, 16'hBEEF};
    tbl[2]  = '{1'b1, 4'd5,  16'h1234, 4'd5,  4'd3,  16'h1234, 16'hBEEF, 16'h0000, 16'h1234};
    tbl[3]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  16'h1234, 16'h1234, 16'h1234, 16'h1234};
    tbl[4]  = '{1'b1, 4'd3,  16'h0A0A, 4'd3,  4'd3,  16'h0A0A, 16'h0A0A, 16'hBEEF, 16'h0A0A};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd5,  16'h0A0A, 16'h1234, 16'h0A0A, 16'h0A0A};
    tbl[6]  = '{1'b1, 4'd15, 16'hFFFF, 4'd15, 4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd3,  16'h0000, 16'h0A0A, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b1, 4'd0,  16'h5555, 4'd0,  4'd0,  16'h5555, 16'h5555, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd14, 16'h5555, 16'h0000, 16'h5555, 16'h0000};
    tbl[10] = '{1'b1, 4'd13, 16'h7777, 4'd13, 4'd3,  16'h7777, 16'h0A0A, 16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 4'd0,  16'h0000, 4'd13, 4'd13, 16'h7777, 16'h7777, 16'h7777, 16'h0000};

    reset = 1'b1; io_in = '0;
    drive(1'b0, 4'd0, 16'h0, 4'd3, 4'd4);
    ticks(2);
    chk("reset rdata_a", rdA, 16'h0);
    chk("reset rdata_b", rdB, 16'h0);
    chk("reset io_press", press, 16'h0);
    reset = 1'b0;

    // Table: expectations queued at drive time, popped when the read is sampled.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb);
      sb.push_back('{i, tbl[i].expA, tbl[i].expB, tbl[i].expNb, tbl[i].expZ});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d rdata_a", e.idx), rdA, e.expA);
      chk($sformatf("vec%0d rdata_b", e.idx), rdB, e.expB);
      chk($sformatf("vec%0d nobypass rdata_a", e.idx), nbA, e.expNb);
      chk($sformatf("vec%0d zeroR0 rdata_a", e.idx), zA, e.expZ);
      tick();
    end

    // Input path latency and edge flag.
    drive(1'b0, 4'd0, 16'h0, 4'd15, 4'd3);
    io_in = 16'h0011;
    ticks(2);
    chk("io 2 edges read", rdA, 16'h0000);
    chk("io 2 edges press", press, 16'h0000);
    tick();
    chk("io 3 edges read", rdA, 16'h0011);
    chk("io 3 edges press", press, 16'h0011);
    ticks(3);
    chk("io held press", press, 16'h0011);

    // Write-1-to-clear leaves the IO register itself alone.
    drive(1'b1, 4'd15, 16'h0001, 4'd15, 4'd3);
    @(negedge clk);
    chk("io write no bypass", rdA, 16'h0011);
    tick();
    we = 1'b0;
    chk("w1c press", press, 16'h0010);
    chk("w1c io reg", rdA, 16'h0011);

    // New rise on bit 0 landing on the same edge as its clear: set wins.
    io_in = 16'h0010;
    ticks(4);
    chk("fall no set", press, 16'h0010);
    io_in = 16'h0011;
    ticks(2);
    drive(1'b1, 4'd15, 16'h0001, 4'd15, 4'd3);
    tick();
    we = 1'b0;
    chk("set beats clear", press, 16'h0011);

    // Held-high inputs do not re-arm after a clear.
    drive(1'b1, 4'd15, 16'h0011, 4'd15, 4'd3);
    tick();
    we = 1'b0;
    chk("clear both", press, 16'h0000);
    ticks(3);
    chk("held no reset", press, 16'h0000);

    io_in = 16'h0001;
    ticks(4);
    io_in = 16'h0011;
    ticks(3);
    chk("rearm bit4", press, 16'h0010);

    // Reset mid-stream with a write pending.
    drive(1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd15);
    tick();
    we = 1'b0;
    chk("pre-reset r3", rdA, 16'hBEEF);
    reset = 1'b1;
    drive(1'b1, 4'd3, 16'h1111, 4'd3, 4'd15);
    @(negedge clk);
    chk("reset cycle bypass", rdA, 16'h1111);
    chk("reset cycle io", rdB, 16'h0011);
    tick();
    reset = 1'b0;
    we = 1'b0;
    @(negedge clk);
    chk("post-reset r3", rdA, 16'h0000);
    chk("post-reset io", rdB, 16'h0000);
    chk("post-reset press", press, 16'h0000);
    chk("post-reset nobypass r3", nbA, 16'h0000);
    ticks(3);
    chk("post-reset io rise", press, 16'h0011);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
